// File: rtl/gshare_predictor_if.sv
// Fetch/prediction, commit-training, flush and perf-counter bundle between
// the front end / ROB (master) and gshare_predictor (slave).
interface gshare_predictor_if #(
  parameter int GHR_W = 8
);
  logic             fetch_valid;
  logic [31:0]      instr;
  logic [31:0]      cur_pc;
  logic             if_jump;
  logic [31:0]      predict_pc;
  logic [GHR_W-1:0] predict_ghr;

  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic [GHR_W-1:0] commit_ghr;
  logic             commit_taken;
  logic             commit_mispredict;
  logic             rob_flush;

  logic [31:0]      br_cnt;
  logic [31:0]      miss_cnt;

  modport master (
    output fetch_valid, instr, cur_pc,
    output commit_valid, commit_pc, commit_ghr, commit_taken, commit_mispredict,
    output rob_flush,
    input  if_jump, predict_pc, predict_ghr,
    input  br_cnt, miss_cnt
  );

  modport slave (
    input  fetch_valid, instr, cur_pc,
    input  commit_valid, commit_pc, commit_ghr, commit_taken, commit_mispredict,
    input  rob_flush,
    output if_jump, predict_pc, predict_ghr,
    output br_cnt, miss_cnt
  );
endinterface

// File: rtl/gshare_predictor.sv
// gshare / bimodal direction predictor: 2-bit counter PHT, speculative history
// repaired from committed history on flush, commit-time training, perf counters.
module gshare_predictor #(
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = 8,      // legal range 1..PHT_IDX_W
  parameter bit GSHARE    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  input logic               rdy,
  gshare_predictor_if.slave bp
);
  localparam int         PHT_DEPTH  = 1 << PHT_IDX_W;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef logic [PHT_IDX_W-1:0] idx_t;
  typedef logic [GHR_W-1:0]     ghr_t;

  // Bimodal builds still track history but never fold it into the index.
  function automatic idx_t pht_idx(input logic [31:0] pc, input ghr_t h);
    idx_t hx;
    hx = GSHARE ? idx_t'(h) : '0;
    return pc[PHT_IDX_W+1:2] ^ hx;
  endfunction

  function automatic ghr_t ghr_shift(input ghr_t h, input logic t);
    ghr_t r;
    r    = h << 1;
    r[0] = t;
    return r;
  endfunction

  logic [1:0]  pht_q [PHT_DEPTH];
  ghr_t        spec_ghr_q, spec_ghr_d;
  ghr_t        cmt_ghr_q, cmt_ghr_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Fetch-side decode and prediction, all combinational.
  logic [6:0]  opcode;
  logic        is_jal, is_branch;
  logic [31:0] imm_j, imm_b;
  idx_t        fetch_idx;
  logic [1:0]  fetch_ctr;
  logic        if_jump;

  assign opcode    = bp.instr[6:0];
  assign is_jal    = bp.fetch_valid && (opcode == OPC_JAL);
  assign is_branch = bp.fetch_valid && (opcode == OPC_BRANCH);
  assign imm_j     = {{12{bp.instr[31]}}, bp.instr[19:12], bp.instr[20], bp.instr[30:21], 1'b0};
  assign imm_b     = {{20{bp.instr[31]}}, bp.instr[7], bp.instr[30:25], bp.instr[11:8], 1'b0};
  assign fetch_idx = pht_idx(bp.cur_pc, spec_ghr_q);
  assign fetch_ctr = pht_q[fetch_idx];
  assign if_jump   = is_jal || (is_branch && fetch_ctr[1]);

  assign bp.if_jump     = if_jump;
  assign bp.predict_pc  = bp.cur_pc + (if_jump ? (is_jal ? imm_j : imm_b) : 32'd4);
  assign bp.predict_ghr = spec_ghr_q;
  assign bp.br_cnt      = br_cnt_q;
  assign bp.miss_cnt    = miss_cnt_q;

  // Commit-side training: read the old counter, write the saturated result.
  idx_t       train_idx;
  logic [1:0] train_ctr, train_ctr_d;

  assign train_idx = pht_idx(bp.commit_pc, bp.commit_ghr);
  assign train_ctr = pht_q[train_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    train_ctr_d = train_ctr;
    if (bp.commit_taken) begin
      if (train_ctr != 2'b11) train_ctr_d = train_ctr + 2'd1;
    end else begin
      if (train_ctr != 2'b00) train_ctr_d = train_ctr - 2'd1;
    end
  end

  always_comb begin
    cmt_ghr_d  = cmt_ghr_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bp.commit_valid) begin
      cmt_ghr_d = ghr_shift(cmt_ghr_q, bp.commit_taken);
      br_cnt_d  = br_cnt_q + 32'd1;
      if (bp.commit_mispredict) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    // Flush repairs from the post-commit history and drops any fetch shift.
    spec_ghr_d = spec_ghr_q;
    if (bp.rob_flush) begin
      spec_ghr_d = cmt_ghr_d;
    end else if (is_branch) begin
      spec_ghr_d = ghr_shift(spec_ghr_q, if_jump);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the PHT is a flop array and must come up weakly not-taken, so every entry is reset.
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'b01;
      spec_ghr_q <= '0;
      cmt_ghr_q  <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      spec_ghr_q <= spec_ghr_d;
      cmt_ghr_q  <= cmt_ghr_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (bp.commit_valid) pht_q[train_idx] <= train_ctr_d;
    end
  end
endmodule
